// File: rtl/game_over_pkg.sv
// Shared types for the game-over compositor: FSM states, 12-bit RGB, pipeline bundle.
// Latency: n/a (types and a combinational helper only).
// Backpressure: none; the pixel path is a free-running stream.
package game_over_pkg;

   typedef enum logic [1:0] {IDLE, FADE, SHOW} go_state_t;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb12_t;

   // Everything that must travel alongside the word layer's read latency.
   // Syncs are carried active-high so a cleared delay line reads as "no sync".
   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       vde;
      logic       hs_act;
      logic       vs_act;
      rgb12_t     game;
   } pix_bus_t;

   localparam logic [11:0] KEY_COLOR_DEFAULT = 12'h000;

   // Per-channel logical right shift, so no channel bleeds into its neighbour.
   function automatic rgb12_t dim_rgb(rgb12_t c, logic [1:0] sh);
      rgb12_t o;
      o.r = c.r >> sh;
      o.g = c.g >> sh;
      o.b = c.b >> sh;
      return o;
   endfunction

endpackage

// File: rtl/game_over_compositor_pixel_delay.sv
// pixel_delay: N-stage shift register with synchronous active-low clear.
// Latency: N cycles from d to q.
// Backpressure: none; shifts every clock.  Ports: clk, clr_n, d[W], q[W].
module pixel_delay #(
   parameter int W = 1,
   parameter int N = 1
) (
   input  logic         clk,
   input  logic         clr_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] stage [N];

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         for (int i = 0; i < N; i++) stage[i] <= '0;
      end else begin
         stage[0] <= d;
         for (int i = 1; i < N; i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[N-1];

endmodule

// File: rtl/game_over_compositor.sv
// game_over_compositor: merges game layer with game-over word layer, frame-synchronous fade/show FSM.
// Latency: OVER_LAT+1 cycles on every pixel/sync output. Backpressure: none (pixel stream).
// Ports: clk_25MHz, reset_n (sync), DrawX/DrawY, vde, hsync/vsync, game_over, Game_*, Over_* ->
//        Red/Green/Blue, vde_o, hsync_o, vsync_o, overlay_on. Optional macro: GAME_OVER_BLINK_EN.
module game_over_compositor
   import game_over_pkg::*;
#(
   parameter int          OVER_LAT     = 1,
   parameter int          WORD_X       = 80,
   parameter int          WORD_Y       = 100,
   parameter int          WORD_W       = 320,
   parameter int          WORD_H       = 64,
   parameter int          FADE_FRAMES  = 8,
   parameter int          DIM_MAX      = 2,
   parameter logic [11:0] KEY_COLOR    = KEY_COLOR_DEFAULT,
   parameter int          BLINK_FRAMES = 30
) (
   input  logic       clk_25MHz,
   input  logic       reset_n,
   input  logic [9:0] DrawX,
   input  logic [9:0] DrawY,
   input  logic       vde,
   input  logic       hsync,
   input  logic       vsync,
   input  logic       game_over,
   input  logic [3:0] Game_Red,
   input  logic [3:0] Game_Green,
   input  logic [3:0] Game_Blue,
   input  logic [3:0] Over_Red,
   input  logic [3:0] Over_Green,
   input  logic [3:0] Over_Blue,
   output logic [3:0] Red,
   output logic [3:0] Green,
   output logic [3:0] Blue,
   output logic       vde_o,
   output logic       hsync_o,
   output logic       vsync_o,
   output logic       overlay_on
);

   if (OVER_LAT < 1 || OVER_LAT > 4) begin : g_bad_lat
      $error("OVER_LAT must be 1..4");
   end
   if (FADE_FRAMES < 1 || FADE_FRAMES > 255) begin : g_bad_fade
      $error("FADE_FRAMES must be 1..255");
   end
   if (DIM_MAX < 1 || DIM_MAX > 3) begin : g_bad_dim
      $error("DIM_MAX must be 1..3");
   end
   if (BLINK_FRAMES < 1) begin : g_bad_blink
      $error("BLINK_FRAMES must be >= 1");
   end

   // Window bounds in 11 bits so WORD_X+WORD_W may exceed 1023 without wrapping.
   localparam logic [10:0] X_LO      = 11'(WORD_X);
   localparam logic [10:0] X_HI      = 11'(WORD_X + WORD_W);
   localparam logic [10:0] Y_LO      = 11'(WORD_Y);
   localparam logic [10:0] Y_HI      = 11'(WORD_Y + WORD_H);
   localparam logic [7:0]  FADE_LAST = 8'(FADE_FRAMES - 1);
   localparam logic [1:0]  DIM_TOP   = 2'(DIM_MAX);

   // ---------------- alignment to the word layer ----------------
   pix_bus_t pix_in, pix_dl;

   assign pix_in = '{x: DrawX, y: DrawY, vde: vde, hs_act: ~hsync, vs_act: ~vsync,
                     game: '{r: Game_Red, g: Game_Green, b: Game_Blue}};

   pixel_delay #(.W($bits(pix_bus_t)), .N(OVER_LAT)) u_align (
      .clk   (clk_25MHz),
      .clr_n (reset_n),
      .d     (pix_in),
      .q     (pix_dl)
   );

   // ---------------- frame tick ----------------
   logic vsync_prev;
   logic tick;

   assign tick = vsync_prev & ~vsync;

   // ---------------- fade / overlay FSM ----------------
   go_state_t  state_q, state_d;
   logic [1:0] dim_q, dim_d;
   logic [7:0] fcnt_q, fcnt_d;
   logic       blink_vis;

   always_comb begin
      state_d = state_q;
      dim_d   = dim_q;
      fcnt_d  = fcnt_q;
      if (tick) begin
         case (state_q)
            IDLE: begin
               dim_d = 2'd0;
               if (game_over) begin
                  state_d = FADE;
                  fcnt_d  = 8'd0;
               end
            end
            FADE: begin
               // Dropping game_over wins over a dim step on the same tick.
               if (!game_over) begin
                  state_d = IDLE;
                  dim_d   = 2'd0;
                  fcnt_d  = 8'd0;
               end else if (fcnt_q == FADE_LAST) begin
                  fcnt_d = 8'd0;
                  dim_d  = dim_q + 2'd1;
                  if (dim_q + 2'd1 == DIM_TOP) state_d = SHOW;
               end else begin
                  fcnt_d = fcnt_q + 8'd1;
               end
            end
            SHOW: begin
               dim_d = DIM_TOP;
               if (!game_over) begin
                  state_d = IDLE;
                  dim_d   = 2'd0;
               end
            end
            default: begin
               state_d = IDLE;
               dim_d   = 2'd0;
               fcnt_d  = 8'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_25MHz) begin
      if (!reset_n) begin
         vsync_prev <= 1'b1;
         state_q    <= IDLE;
         dim_q      <= 2'd0;
         fcnt_q     <= 8'd0;
      end else begin
         vsync_prev <= vsync;
         state_q    <= state_d;
         dim_q      <= dim_d;
         fcnt_q     <= fcnt_d;
      end
   end

`ifdef GAME_OVER_BLINK_EN
   localparam logic [15:0] BLINK_LAST = 16'(BLINK_FRAMES - 1);
   logic [15:0] bcnt_q, bcnt_d;
   logic        vis_q, vis_d;

   // Counter only runs while SHOW persists; any other tick re-arms it visible.
   always_comb begin
      bcnt_d = bcnt_q;
      vis_d  = vis_q;
      if (tick) begin
         if (state_q == SHOW && state_d == SHOW) begin
            if (bcnt_q == BLINK_LAST) begin
               bcnt_d = 16'd0;
               vis_d  = ~vis_q;
            end else begin
               bcnt_d = bcnt_q + 16'd1;
            end
         end else begin
            bcnt_d = 16'd0;
            vis_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_25MHz) begin
      if (!reset_n) begin
         bcnt_q <= 16'd0;
         vis_q  <= 1'b1;
      end else begin
         bcnt_q <= bcnt_d;
         vis_q  <= vis_d;
      end
   end

   assign blink_vis = vis_q;
`else
   assign blink_vis = 1'b1;
`endif

   // ---------------- compositing ----------------
   rgb12_t over_c, dimmed, pix_c, rgb_q;
   logic   in_win, show_word;

   assign over_c    = '{r: Over_Red, g: Over_Green, b: Over_Blue};
   assign dimmed    = dim_rgb(pix_dl.game, dim_q);
   assign in_win    = ({1'b0, pix_dl.x} >= X_LO) && ({1'b0, pix_dl.x} < X_HI) &&
                      ({1'b0, pix_dl.y} >= Y_LO) && ({1'b0, pix_dl.y} < Y_HI);
   assign show_word = (state_q == SHOW) && in_win && (over_c != KEY_COLOR) && blink_vis;
   assign pix_c     = !pix_dl.vde ? rgb12_t'(12'h000) : (show_word ? over_c : dimmed);

   always_ff @(posedge clk_25MHz) begin
      if (!reset_n) begin
         rgb_q   <= '0;
         vde_o   <= 1'b0;
         hsync_o <= 1'b1;
         vsync_o <= 1'b1;
      end else begin
         rgb_q   <= pix_c;
         vde_o   <= pix_dl.vde;
         hsync_o <= ~pix_dl.hs_act;
         vsync_o <= ~pix_dl.vs_act;
      end
   end

   assign Red        = rgb_q.r;
   assign Green      = rgb_q.g;
   assign Blue       = rgb_q.b;
   assign overlay_on = (state_q == SHOW);

endmodule
